fft_reorder_buffer: RTL

- Parametrised output-reorder stage placed after FftTop.
- Accepts a complex FFT output stream in bit-reversed order and emits each frame in natural order (X[0]..X[N-1]) as a contiguous burst.
- Uses a ping-pong pair of N-entry banks so back-to-back frames stream without stalls.
- Also supports a natural-order pass-through mode for bypass and debug.

---
 rtl/fft_reorder_buffer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fft_reorder_buffer.sv
// Output reorder stage for a streaming FFT. Bit-reversed (or sequential)
// frames are written into one half of a ping-pong memory while the other
// half is read out in natural order as a gapless N-cycle burst.
module fft_reorder_buffer #(
  parameter int unsigned N      = 128,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned BITREV = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   idata_en,
  input  logic [WIDTH-1:0]       idata_r,
  input  logic [WIDTH-1:0]       idata_i,
  output logic                   odata_en,
  output logic [WIDTH-1:0]       odata_r,
  output logic [WIDTH-1:0]       odata_i,
  output logic [$clog2(N)-1:0]   odata_idx,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned DEPTH = 2 * N;

  typedef enum logic {IDLE, READ} state_t;

  // Two N-entry banks; the bank select is the address MSB.
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_cnt, wr_cnt_n;
  logic          wr_bank, wr_bank_n;
  logic          frame_ready, frame_ready_n;
  logic          ready_bank, ready_bank_n;
  logic [AW-1:0] wr_addr;

  state_t        state, state_n;
  logic [AW-1:0] rd_addr, rd_addr_n;
  logic          rd_bank, rd_bank_n;
  logic          busy_n;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < int'(AW); b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  // Write address: mirrored count in reorder mode, plain count in delay mode.
  always_comb begin
    wr_addr = (BITREV != 0) ? bitrev(wr_cnt) : wr_cnt;
  end

  // Write-side next state: count samples, flip banks and flag a full frame.
  always_comb begin
    wr_cnt_n      = wr_cnt;
    wr_bank_n     = wr_bank;
    frame_ready_n = 1'b0;
    ready_bank_n  = ready_bank;
    if (idata_en) begin
      wr_cnt_n = wr_cnt + AW'(1);
      if (wr_cnt == AW'(N - 1)) begin
        wr_bank_n     = ~wr_bank;
        frame_ready_n = 1'b1;
        ready_bank_n  = wr_bank;
      end
    end
  end

  // Write-side state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_cnt      <= '0;
      wr_bank     <= 1'b0;
      frame_ready <= 1'b0;
      ready_bank  <= 1'b0;
    end else begin
      wr_cnt      <= wr_cnt_n;
      wr_bank     <= wr_bank_n;
      frame_ready <= frame_ready_n;
      ready_bank  <= ready_bank_n;
    end
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clock) begin
    if (idata_en) mem[{wr_bank, wr_addr}] <= {idata_r, idata_i};
  end

  // Read FSM next state; a frame arriving on the last address chains straight on.
  always_comb begin
    state_n   = state;
    rd_addr_n = rd_addr;
    rd_bank_n = rd_bank;
    case (state)
      IDLE: begin
        if (frame_ready) begin
          state_n   = READ;
          rd_addr_n = '0;
          rd_bank_n = ready_bank;
        end
      end
      READ: begin
        if (rd_addr == AW'(N - 1)) begin
          if (frame_ready) begin
            rd_addr_n = '0;
            rd_bank_n = ready_bank;
          end else begin
            state_n = IDLE;
          end
        end else begin
          rd_addr_n = rd_addr + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (wr_cnt_n != '0) || (state_n == READ) || frame_ready_n;
  end

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_addr <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_n;
      rd_addr <= rd_addr_n;
      rd_bank <= rd_bank_n;
    end
  end

  // Registered memory read and outputs; data and index hold between bursts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      odata_en  <= 1'b0;
      odata_r   <= '0;
      odata_i   <= '0;
      odata_idx <= '0;
      busy      <= 1'b0;
    end else begin
      odata_en <= (state == READ);
      busy     <= busy_n;
      if (state == READ) begin
        {odata_r, odata_i} <= mem[{rd_bank, rd_addr}];
        odata_idx          <= rd_addr;
      end
    end
  end

endmodule
